// File: rtl/divider_seq_nbit.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with optional
// two's-complement operands and divide-by-zero reporting behind a start/busy/done handshake.
module divider_seq_nbit #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Dvd,
    input  logic [WIDTH-1:0] Dsr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr_mag;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, zero;

    logic             accept;
    logic             dvd_neg, dsr_neg;
    logic [WIDTH-1:0] dvd_mag, dsr_abs;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_lo;
    logic [WIDTH-1:0] q_final, r_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)              state_nxt = (Dsr == '0) ? DONE : RUN;
                else if (state == DONE) state_nxt = IDLE;
            end
            RUN:     if (cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand conditioning, one restoring step, and final sign fix-up.
    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        dvd_neg = (SIGNED != 0) && Dvd[WIDTH-1];
        dsr_neg = (SIGNED != 0) && Dsr[WIDTH-1];
        dvd_mag = dvd_neg ? -Dvd : Dvd;
        dsr_abs = dsr_neg ? -Dsr : Dsr;
        // rem[WIDTH] is always 0 between steps; shifting the full register keeps it in use.
        trial   = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
        fits    = trial >= {1'b0, dsr_mag};
        rem_lo  = rem[WIDTH-1:0];
        if (zero) begin
            q_final = '1;
            r_final = quo;
        end else begin
            q_final = neg_q ? -quo : quo;
            r_final = neg_r ? -rem_lo : rem_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            dsr_mag     <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            if (state == DONE) begin
                Q           <= q_final;
                R           <= r_final;
                div_by_zero <= zero;
            end else if (accept) begin
                div_by_zero <= 1'b0;
            end

            if (accept) begin
                zero    <= (Dsr == '0);
                quo     <= (Dsr == '0) ? Dvd : dvd_mag;
                dsr_mag <= dsr_abs;
                rem     <= '0;
                cnt     <= CW'(WIDTH - 1);
                neg_q   <= dvd_neg ^ dsr_neg;
                neg_r   <= dvd_neg;
            end else if (state == RUN) begin
                rem <= fits ? (trial - {1'b0, dsr_mag}) : trial;
                quo <= {quo[WIDTH-2:0], fits};
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_divider_seq_nbit.sv
// Directed and random checks of divider_seq_nbit: 4-bit unsigned, 8-bit unsigned and
// 8-bit signed instances sharing one clock and reset.
module tb_divider_seq_nbit;

    logic       clk = 1'b0;
    logic       rst;
    logic       st_u4, st_u8, st_s8;
    logic [7:0] dvd, dsr;

    logic [3:0] q_u4, r_u4;
    logic [7:0] q_u8, r_u8, q_s8, r_s8;
    logic       b_u4, d_u4, z_u4, b_u8, d_u8, z_u8, b_s8, d_s8, z_s8;

    int         sel;
    logic [7:0] v_q, v_r;
    logic       v_busy, v_done, v_z;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    divider_seq_nbit #(.WIDTH(4), .SIGNED(0)) u4 (
        .clk(clk), .rst(rst), .start(st_u4), .Dvd(dvd[3:0]), .Dsr(dsr[3:0]),
        .Q(q_u4), .R(r_u4), .busy(b_u4), .done(d_u4), .div_by_zero(z_u4));
    divider_seq_nbit #(.WIDTH(8), .SIGNED(0)) u8 (
        .clk(clk), .rst(rst), .start(st_u8), .Dvd(dvd), .Dsr(dsr),
        .Q(q_u8), .R(r_u8), .busy(b_u8), .done(d_u8), .div_by_zero(z_u8));
    divider_seq_nbit #(.WIDTH(8), .SIGNED(1)) s8 (
        .clk(clk), .rst(rst), .start(st_s8), .Dvd(dvd), .Dsr(dsr),
        .Q(q_s8), .R(r_s8), .busy(b_s8), .done(d_s8), .div_by_zero(z_s8));

    always_comb begin
        v_q = {4'b0, q_u4}; v_r = {4'b0, r_u4};
        v_busy = b_u4; v_done = d_u4; v_z = z_u4;
        if (sel == 1) begin
            v_q = q_u8; v_r = r_u8; v_busy = b_u8; v_done = d_u8; v_z = z_u8;
        end else if (sel == 2) begin
            v_q = q_s8; v_r = r_s8; v_busy = b_s8; v_done = d_s8; v_z = z_s8;
        end
    end

    typedef struct {
        int         sel;
        logic [7:0] a, b, q, r;
        logic       z;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    endtask

    task automatic start_op(input int s, input logic [7:0] a, input logic [7:0] b);
        sel = s;
        @(negedge clk);
        dvd = a; dsr = b;
        st_u4 = (s == 0); st_u8 = (s == 1); st_s8 = (s == 2);
        @(posedge clk);
        #1;
        st_u4 = 1'b0; st_u8 = 1'b0; st_s8 = 1'b0;
    endtask

    // Returns edges from the accept edge to the done edge and the busy cycles seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (v_busy) bcnt++;
        end while (!v_done && lat < 40);
        chk("done_seen", lat, v_done, 1);
    endtask

    initial begin
        int lat, bcnt, extra, w;
        logic [7:0] eq, er;
        logic ez;
        int sa, sb;

        tbl[0]  = '{0, 8'd13,  8'd4,   8'd3,   8'd1,   1'b0};
        tbl[1]  = '{0, 8'd15,  8'd1,   8'd15,  8'd0,   1'b0};
        tbl[2]  = '{0, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        tbl[3]  = '{0, 8'd7,   8'd0,   8'h0F,  8'd7,   1'b1};
        tbl[4]  = '{1, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
        tbl[5]  = '{1, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        tbl[6]  = '{1, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        tbl[7]  = '{1, 8'd9,   8'd0,   8'hFF,  8'd9,   1'b1};
        tbl[8]  = '{1, 8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
        tbl[9]  = '{1, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        tbl[10] = '{1, 8'd100, 8'd10,  8'd10,  8'd0,   1'b0};
        tbl[11] = '{2, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0};
        tbl[12] = '{2, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0};
        tbl[13] = '{2, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0};
        tbl[14] = '{2, 8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0};
        tbl[15] = '{2, 8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0};
        tbl[16] = '{2, 8'h85,  8'h00,  8'hFF,  8'h85,  1'b1};

        rst = 1'b1; st_u4 = 1'b0; st_u8 = 1'b0; st_s8 = 1'b0;
        dvd = '0; dsr = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_q", s, v_q, 0);
            chk("rst_r", s, v_r, 0);
            chk("rst_flags", s, {v_busy, v_done, v_z}, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            w = (tbl[i].sel == 0) ? 4 : 8;
            start_op(tbl[i].sel, tbl[i].a, tbl[i].b);
            wait_done(lat, bcnt);
            chk("vec_q", i, v_q, tbl[i].q);
            chk("vec_r", i, v_r, tbl[i].r);
            chk("vec_dbz", i, v_z, tbl[i].z);
            chk("vec_lat", i, lat, tbl[i].z ? 1 : w + 1);
            chk("vec_busy", i, bcnt, tbl[i].z ? 0 : w);
        end

        // start pulsed mid-RUN with new operands is ignored
        start_op(1, 8'd200, 8'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        dvd = 8'd50; dsr = 8'd5; st_u8 = 1'b1;
        @(negedge clk);
        st_u8 = 1'b0;
        wait_done(lat, bcnt);
        chk("midrun_q", 0, v_q, 28);
        chk("midrun_r", 0, v_r, 4);
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (v_done || v_busy) extra++;
        end
        chk("midrun_no_op", 0, extra, 0);

        // start held through DONE: second op accepted with no idle cycle
        sel = 1;
        @(negedge clk);
        dvd = 8'd200; dsr = 8'd7; st_u8 = 1'b1;
        @(posedge clk);
        #1;
        dvd = 8'd100; dsr = 8'd10;
        wait_done(lat, bcnt);
        st_u8 = 1'b0;
        chk("b2b_q1", 0, v_q, 28);
        chk("b2b_r1", 0, v_r, 4);
        chk("b2b_lat1", 0, lat, 9);
        wait_done(lat, bcnt);
        chk("b2b_q2", 0, v_q, 10);
        chk("b2b_r2", 0, v_r, 0);
        chk("b2b_lat2", 0, lat, 9);

        // asynchronous reset mid-RUN
        start_op(1, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstrun_q", 0, v_q, 0);
        chk("rstrun_r", 0, v_r, 0);
        chk("rstrun_flags", 0, {v_busy, v_done, v_z}, 0);
        @(negedge clk);
        rst = 1'b0;
        start_op(1, 8'd100, 8'd10);
        wait_done(lat, bcnt);
        chk("rstrun_q2", 0, v_q, 10);
        chk("rstrun_r2", 0, v_r, 0);

        // random operands against the behavioural operators
        for (int n = 0; n < 600; n++) begin
            int s;
            logic [7:0] a, b;
            s = n % 3;
            a = 8'($urandom);
            b = (n % 17 == 0) ? 8'd0 : 8'($urandom);
            if (s == 0) begin
                a[7:4] = 4'd0; b[7:4] = 4'd0;
            end
            ez = (b == 8'd0);
            if (ez) begin
                eq = (s == 0) ? 8'h0F : 8'hFF;
                er = a;
            end else if (s == 2) begin
                sa = $signed(a);
                sb = $signed(b);
                eq = 8'(sa / sb);
                er = 8'(sa % sb);
            end else begin
                eq = a / b;
                er = a % b;
            end
            start_op(s, a, b);
            wait_done(lat, bcnt);
            chk("rnd_q", n, v_q, eq);
            chk("rnd_r", n, v_r, er);
            chk("rnd_dbz", n, v_z, ez);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
